branch_resolve_unit: RTL and testbench

Multi-channel, registered successor to the single-slot branch resolver. It resolves up to `CHANNELS` control-flow instructions per cycle from the branch reservation stations and selects the oldest mispredict by ROB age. It issues one registered redirect to the front end and queues predictor-update records in a small FIFO toward the BTB/BHT. It sits between the branch issue ports and the fetch-redirect / predictor-training paths.

---
 rtl/cpu_defs.sv | 78 +++++++
 rtl/branch_resolve_unit_core.sv | 107 ++++++++++
 rtl/branch_resolve_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU type definitions for the branch resolution path.
// Optional feature macro: BRANCH_LIKELY_EN adds the branch-likely opcodes.
package cpu_defs;

    typedef logic [31:0] uint32_t;

    localparam int ROB_IDX_W_DEF = 5;
    typedef logic [ROB_IDX_W_DEF-1:0] rob_idx_t;

    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_BEQ,
        OP_BNE,
        OP_BLEZ,
        OP_BGTZ,
        OP_BLTZ,
        OP_BGEZ,
        OP_BLTZAL,
        OP_BGEZAL,
        OP_JAL,
        OP_JALR
`ifdef BRANCH_LIKELY_EN
        ,
        OP_BEQL,
        OP_BNEL,
        OP_BLEZL,
        OP_BGTZL,
        OP_BLTZL,
        OP_BGEZL
`endif
    } op_e;

    // Control-flow class reported to the predictor.
    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JUMP,
        CF_CALL
    } cf_e;

    typedef struct packed {
        op_e  op;
        logic is_controlflow;
    } decoded_t;

    typedef struct packed {
        logic       valid;
        logic       taken;
        uint32_t    target;
        logic [1:0] counter;
    } pred_t;

    // instr_idx holds the low 26 bits of the instruction word.
    typedef struct packed {
        uint32_t     reg1;
        uint32_t     reg2;
        uint32_t     pc;
        logic [25:0] instr_idx;
        pred_t       pred;
        decoded_t    decoded;
    } reserve_station_t;

    typedef struct packed {
        uint32_t    pc;
        uint32_t    target;
        logic       taken;
        logic [1:0] counter;
        cf_e        cf;
        logic       mispredict;
        logic       nullify;
    } branch_resolved_t;

    // Sign-extended word offset of a conditional branch.
    function automatic uint32_t sext_branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_core.sv
// Per-channel combinational branch resolver: direction, target, mispredict.
// Optional feature macro: BRANCH_LIKELY_EN decodes the branch-likely opcodes.
module branch_resolve_core
    import cpu_defs::*;
(
    input  logic             valid,
    input  reserve_station_t rs,
    output logic             participate,
    output branch_resolved_t rec,
    output uint32_t          redirect_pc,
    output uint32_t          link
);

    uint32_t pc_plus4;
    uint32_t br_target;
    uint32_t jal_target;
    logic    sign;
    logic    eq;
    logic    taken;
    uint32_t target;
    logic    mispredict;
    logic    nullify;
    logic    is_cond;
    logic    is_jump;
    cf_e     cf;
`ifdef BRANCH_LIKELY_EN
    logic    likely;
`endif

    // Address arithmetic and operand comparisons shared by all ops.
    always_comb begin
        pc_plus4   = rs.pc + 32'd4;
        link       = rs.pc + 32'd8;
        br_target  = pc_plus4 + sext_branch_offset(rs.instr_idx[15:0]);
        jal_target = {pc_plus4[31:28], rs.instr_idx, 2'b00};
        sign       = rs.reg1[31];
        eq         = (rs.reg1 == rs.reg2);
    end

    // Decode the op into direction, target and mispredict.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        taken      = 1'b0;
        target     = '0;
        mispredict = 1'b1;
        nullify    = 1'b0;
        is_cond    = 1'b0;
        is_jump    = 1'b0;
        cf         = CF_NONE;
`ifdef BRANCH_LIKELY_EN
        likely     = 1'b0;
`endif
        case (rs.decoded.op)
            OP_BEQ:    begin is_cond = 1'b1; cf = CF_BRANCH; taken = eq;           end
            OP_BNE:    begin is_cond = 1'b1; cf = CF_BRANCH; taken = !eq;          end
            OP_BLEZ:   begin is_cond = 1'b1; cf = CF_BRANCH; taken = eq | sign;    end
            OP_BGTZ:   begin is_cond = 1'b1; cf = CF_BRANCH; taken = !eq & !sign;  end
            OP_BLTZ:   begin is_cond = 1'b1; cf = CF_BRANCH; taken = sign;         end
            OP_BGEZ:   begin is_cond = 1'b1; cf = CF_BRANCH; taken = !sign;        end
            OP_BLTZAL: begin is_cond = 1'b1; cf = CF_CALL;   taken = sign;         end
            OP_BGEZAL: begin is_cond = 1'b1; cf = CF_CALL;   taken = !sign;        end
            OP_JAL:    begin is_jump = 1'b1; cf = CF_CALL;   taken = 1'b1; target = jal_target; end
            OP_JALR:   begin is_jump = 1'b1; cf = CF_JUMP;   taken = 1'b1; target = rs.reg1;    end
`ifdef BRANCH_LIKELY_EN
            OP_BEQL:   begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = eq;          end
            OP_BNEL:   begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = !eq;         end
            OP_BLEZL:  begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = eq | sign;   end
            OP_BGTZL:  begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = !eq & !sign; end
            OP_BLTZL:  begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = sign;        end
            OP_BGEZL:  begin is_cond = 1'b1; likely = 1'b1; cf = CF_BRANCH; taken = !sign;       end
`endif
            default:   ;
        endcase

        if (is_cond) begin
            target     = br_target;
            mispredict = rs.pred.valid & (rs.pred.taken ^ taken);
            if (taken) begin
                mispredict = mispredict | (rs.pred.target != target) | !rs.pred.valid;
            end
        end else if (is_jump) begin
            mispredict = (rs.pred.target != target) | !rs.pred.valid;
        end

`ifdef BRANCH_LIKELY_EN
        // A not-taken likely branch always redirects and annuls its delay slot.
        if (likely && !taken) begin
            mispredict = 1'b1;
            nullify    = 1'b1;
        end
`endif
    end

    // Pack the predictor-update record and the fetch restart address.
    always_comb begin
        participate    = valid & rs.decoded.is_controlflow;
        redirect_pc    = taken ? target : link;
        rec.pc         = rs.pc;
        rec.target     = target;
        rec.taken      = taken;
        rec.counter    = rs.pred.counter;
        rec.cf         = cf;
        rec.mispredict = mispredict;
        rec.nullify    = nullify;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-channel branch resolver: oldest-mispredict redirect select,
// registered results/redirect and a predictor-update FIFO.
// Optional feature macro: BRANCH_LIKELY_EN drives redirect_nullify.
module branch_resolve_unit
    import cpu_defs::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ROB_IDX_W  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [CHANNELS-1:0]  rs_valid,
    input  reserve_station_t     rs [CHANNELS],
    input  logic [ROB_IDX_W-1:0] rs_rob_idx [CHANNELS],
    input  logic [ROB_IDX_W-1:0] rob_head,
    output logic                 rs_ready,
    output logic [CHANNELS-1:0]  result_valid,
    output uint32_t              result [CHANNELS],
    output logic                 redirect_valid,
    output uint32_t              redirect_pc,
    output logic [ROB_IDX_W-1:0] redirect_rob_idx,
    output logic                 redirect_nullify,
    output logic                 upd_valid,
    output branch_resolved_t     upd,
    input  logic                 upd_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-channel resolver outputs.
    logic [CHANNELS-1:0] cf_valid;
    branch_resolved_t    rec [CHANNELS];
    uint32_t             ch_redirect_pc [CHANNELS];
    uint32_t             ch_link [CHANNELS];

    logic                accept;
    logic [CHANNELS-1:0] enq_mask;

    // Redirect selection.
    logic                 sel_found;
    logic [ROB_IDX_W-1:0] sel_age;
    logic [ROB_IDX_W-1:0] sel_idx;
    uint32_t              sel_pc;

    // Stage-1 registers.
    logic [CHANNELS-1:0]  result_valid_d, result_valid_q;
    uint32_t              result_d [CHANNELS];
    uint32_t              result_q [CHANNELS];
    logic                 redirect_valid_d, redirect_valid_q;
    uint32_t              redirect_pc_d, redirect_pc_q;
    logic [ROB_IDX_W-1:0] redirect_rob_idx_d, redirect_rob_idx_q;

    // Update FIFO.
    branch_resolved_t mem_d [FIFO_DEPTH];
    branch_resolved_t mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] free_slots;
    logic             deq;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_core
        branch_resolve_core u_core (
            .valid       (rs_valid[g]),
            .rs          (rs[g]),
            .participate (cf_valid[g]),
            .rec         (rec[g]),
            .redirect_pc (ch_redirect_pc[g]),
            .link        (ch_link[g])
        );
    end

    // Space check uses the registered count only, so a same-cycle dequeue is not credited.
    always_comb begin
        free_slots = CNT_W'(FIFO_DEPTH) - count_q;
        rs_ready   = (free_slots >= CNT_W'(CHANNELS));
        accept     = rs_ready & !flush;
        enq_mask   = cf_valid & {CHANNELS{accept}};
    end

    // Pick the mispredicting channel closest to the ROB head; ties keep the lower channel.
    always_comb begin
        logic [ROB_IDX_W-1:0] age;
        age       = '0;
        sel_found = 1'b0;
        sel_age   = '0;
        sel_idx   = '0;
        sel_pc    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enq_mask[i] && rec[i].mispredict) begin
                age = rs_rob_idx[i] - rob_head;
                if (!sel_found || (age < sel_age)) begin
                    sel_found = 1'b1;
                    sel_age   = age;
                    sel_idx   = rs_rob_idx[i];
                    sel_pc    = ch_redirect_pc[i];
                end
            end
        end
    end

    // Next-state for the link results and the redirect pulse.
    always_comb begin
        result_valid_d     = enq_mask;
        for (int i = 0; i < CHANNELS; i++) begin
            result_d[i] = enq_mask[i] ? ch_link[i] : '0;
        end
        redirect_valid_d   = sel_found;
        redirect_pc_d      = sel_found ? sel_pc  : redirect_pc_q;
        redirect_rob_idx_d = sel_found ? sel_idx : redirect_rob_idx_q;
    end

    // Stage-1 registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            result_valid_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                result_q[i] <= '0;
            end
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            redirect_rob_idx_q <= '0;
        end else begin
            result_valid_q     <= result_valid_d;
            result_q           <= result_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            redirect_rob_idx_q <= redirect_rob_idx_d;
        end
    end

`ifdef BRANCH_LIKELY_EN
    logic sel_nullify;
    logic redirect_nullify_d, redirect_nullify_q;

    // Nullify flag of the winning channel.
    always_comb begin
        logic [ROB_IDX_W-1:0] age_n;
        logic                 found_n;
        logic [ROB_IDX_W-1:0] best_n;
        age_n       = '0;
        found_n     = 1'b0;
        best_n      = '0;
        sel_nullify = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enq_mask[i] && rec[i].mispredict) begin
                age_n = rs_rob_idx[i] - rob_head;
                if (!found_n || (age_n < best_n)) begin
                    found_n     = 1'b1;
                    best_n      = age_n;
                    sel_nullify = rec[i].nullify;
                end
            end
        end
        redirect_nullify_d = sel_found & sel_nullify;
    end

    // Registered nullify alongside the redirect pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_nullify_q <= 1'b0;
        end else begin
            redirect_nullify_q <= redirect_nullify_d;
        end
    end

    assign redirect_nullify = redirect_nullify_q;
`else
    assign redirect_nullify = 1'b0;
`endif

    // FIFO next state: pack accepted records lower channel first, pop on handshake.
    always_comb begin
        logic [PTR_W-1:0] wp;
        mem_d = mem_q;
        wp    = wr_ptr_q;
        n_enq = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enq_mask[i]) begin
                mem_d[wp] = rec[i];
                wp        = wp + PTR_W'(1);
                n_enq     = n_enq + CNT_W'(1);
            end
        end
        deq      = upd_valid & upd_ready;
        wr_ptr_d = wp;
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + n_enq - CNT_W'(deq);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
        mem_q <= mem_d;
    end

    // Output drive.
    always_comb begin
        result_valid     = result_valid_q;
        result           = result_q;
        redirect_valid   = redirect_valid_q;
        redirect_pc      = redirect_pc_q;
        redirect_rob_idx = redirect_rob_idx_q;
        upd_valid        = (count_q != '0);
        upd              = upd_valid ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (CHANNELS=2, FIFO_DEPTH=4).
// Define BRANCH_LIKELY_EN to also exercise the branch-likely path.
module tb_branch_resolve_unit;
    import cpu_defs::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       rs_valid;
    reserve_station_t rs [2];
    logic [4:0]       rs_rob_idx [2];
    logic [4:0]       rob_head;
    logic             rs_ready;
    logic [1:0]       result_valid;
    uint32_t          result [2];
    logic             redirect_valid;
    uint32_t          redirect_pc;
    logic [4:0]       redirect_rob_idx;
    logic             redirect_nullify;
    logic             upd_valid;
    branch_resolved_t upd;
    logic             upd_ready;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.CHANNELS(2), .ROB_IDX_W(5), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .rs_valid         (rs_valid),
        .rs               (rs),
        .rs_rob_idx       (rs_rob_idx),
        .rob_head         (rob_head),
        .rs_ready         (rs_ready),
        .result_valid     (result_valid),
        .result           (result),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_rob_idx (redirect_rob_idx),
        .redirect_nullify (redirect_nullify),
        .upd_valid        (upd_valid),
        .upd              (upd),
        .upd_ready        (upd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic reserve_station_t mk(input op_e op, input uint32_t r1, input uint32_t r2,
                                            input uint32_t pc, input logic [25:0] idx,
                                            input logic pv, input logic pt, input uint32_t ptgt);
        reserve_station_t r;
        r = '0;
        r.reg1                   = r1;
        r.reg2                   = r2;
        r.pc                     = pc;
        r.instr_idx              = idx;
        r.pred.valid             = pv;
        r.pred.taken             = pt;
        r.pred.target            = ptgt;
        r.pred.counter           = 2'b01;
        r.decoded.op             = op;
        r.decoded.is_controlflow = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_valid      = 2'b00;
        flush         = 1'b0;
        rs[0]         = '0;
        rs[1]         = '0;
        rs_rob_idx[0] = '0;
        rs_rob_idx[1] = '0;
    endtask

    uint32_t fill_pc [4];

    initial begin
        rst       = 1'b1;
        upd_ready = 1'b0;
        rob_head  = '0;
        idle();
        #12;
        check("rst_result_valid", result_valid, 2'b00);
        check("rst_result0", result[0], 32'h0);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_redirect_idx", redirect_rob_idx, 5'd0);
        check("rst_nullify", redirect_nullify, 1'b0);
        check("rst_upd_valid", upd_valid, 1'b0);
        check("rst_upd_pc", upd.pc, 32'h0);
        check("rst_rs_ready", rs_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, predicted not-taken.
        rs[0]         = mk(OP_BEQ, 32'd5, 32'd5, 32'h8000_0000, 26'h4, 1'b1, 1'b0, 32'h0);
        rs_rob_idx[0] = 5'd3;
        rs_valid      = 2'b01;
        step();
        check("beq_redirect_valid", redirect_valid, 1'b1);
        check("beq_redirect_pc", redirect_pc, 32'h8000_0014);
        check("beq_redirect_idx", redirect_rob_idx, 5'd3);
        check("beq_result_valid", result_valid, 2'b01);
        check("beq_result0", result[0], 32'h8000_0008);
        check("beq_upd_valid", upd_valid, 1'b1);
        check("beq_upd_taken", upd.taken, 1'b1);
        check("beq_upd_mispredict", upd.mispredict, 1'b1);
        check("beq_upd_target", upd.target, 32'h8000_0014);
        idle();
        step();
        check("beq_pulse_low", redirect_valid, 1'b0);
        check("beq_upd_held", upd_valid, 1'b1);
        upd_ready = 1'b1;
        step();
        check("beq_drained", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // JAL on channel 1, correctly predicted.
        rs[1]         = mk(OP_JAL, 32'h0, 32'h0, 32'h8000_1000, 26'h100, 1'b1, 1'b1, 32'h8000_0400);
        rs_rob_idx[1] = 5'd4;
        rs_valid      = 2'b10;
        step();
        check("jal_no_redirect", redirect_valid, 1'b0);
        check("jal_result_valid", result_valid, 2'b10);
        check("jal_result1", result[1], 32'h8000_1008);
        check("jal_upd_target", upd.target, 32'h8000_0400);
        check("jal_upd_mispredict", upd.mispredict, 1'b0);
        check("jal_upd_cf", upd.cf, CF_CALL);
        idle();
        upd_ready = 1'b1;
        step();
        check("jal_drained", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // Two mispredicts, oldest found across ROB wrap-around.
        rob_head      = 5'd30;
        rs[0]         = mk(OP_BEQ, 32'd7, 32'd7, 32'h0000_2000, 26'h10, 1'b1, 1'b0, 32'h0);
        rs_rob_idx[0] = 5'd1;
        rs[1]         = mk(OP_BEQ, 32'd1, 32'd2, 32'h0000_1000, 26'h0, 1'b1, 1'b1, 32'h1234);
        rs_rob_idx[1] = 5'd31;
        rs_valid      = 2'b11;
        step();
        check("wrap_redirect_idx", redirect_rob_idx, 5'd31);
        check("wrap_redirect_pc", redirect_pc, 32'h0000_1008);
        check("wrap_upd_head_pc", upd.pc, 32'h0000_2000);
        check("wrap_upd_head_target", upd.target, 32'h0000_2044);
        idle();
        upd_ready = 1'b1;
        step();
        check("wrap_upd_second_pc", upd.pc, 32'h0000_1000);
        check("wrap_upd_second_taken", upd.taken, 1'b0);
        check("wrap_upd_second_mp", upd.mispredict, 1'b1);
        step();
        check("wrap_drained", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // Equal age: lower channel wins; negative branch offset.
        rob_head      = 5'd0;
        rs[0]         = mk(OP_BGTZ, 32'd3, 32'd0, 32'h0000_3000, 26'h8, 1'b1, 1'b0, 32'h0);
        rs_rob_idx[0] = 5'd5;
        rs[1]         = mk(OP_BLTZ, 32'hFFFF_FFFF, 32'd0, 32'h0000_4000, 26'hFFFF, 1'b0, 1'b0, 32'h0);
        rs_rob_idx[1] = 5'd5;
        rs_valid      = 2'b11;
        step();
        check("tie_redirect_valid", redirect_valid, 1'b1);
        check("tie_redirect_pc", redirect_pc, 32'h0000_3024);
        idle();
        upd_ready = 1'b1;
        step();
        check("neg_offset_target", upd.target, 32'h0000_4000);
        check("neg_offset_taken", upd.taken, 1'b1);
        step();
        check("tie_drained", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // Fill the FIFO; third cycle must be dropped.
        fill_pc[0] = 32'h100; fill_pc[1] = 32'h104;
        fill_pc[2] = 32'h200; fill_pc[3] = 32'h204;
        rs[0]    = mk(OP_BEQ, 32'd1, 32'd2, fill_pc[0], 26'h0, 1'b1, 1'b0, 32'h0);
        rs[1]    = mk(OP_BEQ, 32'd1, 32'd2, fill_pc[1], 26'h0, 1'b1, 1'b0, 32'h0);
        rs_valid = 2'b11;
        step();
        check("fill1_rs_ready", rs_ready, 1'b1);
        check("fill1_no_redirect", redirect_valid, 1'b0);
        rs[0] = mk(OP_BEQ, 32'd1, 32'd2, fill_pc[2], 26'h0, 1'b1, 1'b0, 32'h0);
        rs[1] = mk(OP_BEQ, 32'd1, 32'd2, fill_pc[3], 26'h0, 1'b1, 1'b0, 32'h0);
        step();
        check("fill2_rs_ready", rs_ready, 1'b0);
        rs[0] = mk(OP_BEQ, 32'd1, 32'd1, 32'h300, 26'h0, 1'b0, 1'b0, 32'h0);
        rs[1] = mk(OP_BEQ, 32'd1, 32'd2, 32'h304, 26'h0, 1'b1, 1'b0, 32'h0);
        step();
        check("fill3_no_redirect", redirect_valid, 1'b0);
        check("fill3_result_valid", result_valid, 2'b00);
        check("fill3_rs_ready", rs_ready, 1'b0);
        idle();
        upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), upd_valid, 1'b1);
            check($sformatf("drain%0d_pc", k), upd.pc, fill_pc[k]);
            step();
        end
        check("drain_empty", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // Flush with a mispredicting JALR; older FIFO entry kept.
        rs[0]    = mk(OP_BEQ, 32'd1, 32'd2, 32'h600, 26'h0, 1'b1, 1'b0, 32'h0);
        rs_valid = 2'b01;
        step();
        idle();
        flush    = 1'b1;
        rs[0]    = mk(OP_JALR, 32'h4000, 32'h0, 32'h5000, 26'h0, 1'b0, 1'b0, 32'h0);
        rs_valid = 2'b01;
        step();
        check("flush_no_redirect", redirect_valid, 1'b0);
        check("flush_result_valid", result_valid, 2'b00);
        check("flush_upd_valid", upd_valid, 1'b1);
        check("flush_upd_pc", upd.pc, 32'h600);
        idle();
        flush     = 1'b1;
        upd_ready = 1'b1;
        step();
        check("flush_dequeue", upd_valid, 1'b0);
        flush     = 1'b0;
        upd_ready = 1'b0;

`ifdef BRANCH_LIKELY_EN
        // BNEL not taken: forced redirect to pc+8 with nullify.
        rs[0]         = mk(OP_BNEL, 32'd9, 32'd9, 32'h7000, 26'h20, 1'b1, 1'b0, 32'h0);
        rs_rob_idx[0] = 5'd2;
        rs_valid      = 2'b01;
        step();
        check("bnel_redirect_valid", redirect_valid, 1'b1);
        check("bnel_redirect_pc", redirect_pc, 32'h7008);
        check("bnel_nullify", redirect_nullify, 1'b1);
        check("bnel_upd_nullify", upd.nullify, 1'b1);
        idle();
        upd_ready = 1'b1;
        step();
        check("bnel_pulse_low", redirect_nullify, 1'b0);
        upd_ready = 1'b0;
`endif

        // Reset mid-stream with three queued records.
        rs[0]    = mk(OP_BEQ, 32'd1, 32'd2, 32'h800, 26'h0, 1'b1, 1'b0, 32'h0);
        rs[1]    = mk(OP_BEQ, 32'd1, 32'd2, 32'h804, 26'h0, 1'b1, 1'b0, 32'h0);
        rs_valid = 2'b11;
        step();
        rs[0]         = mk(OP_BEQ, 32'd1, 32'd1, 32'h900, 26'h0, 1'b1, 1'b0, 32'h0);
        rs_rob_idx[0] = 5'd2;
        rs_valid      = 2'b01;
        step();
        check("pre_rst_redirect", redirect_valid, 1'b1);
        check("pre_rst_upd_valid", upd_valid, 1'b1);
        check("pre_rst_rs_ready", rs_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_upd_valid", upd_valid, 1'b0);
        check("mid_rst_redirect", redirect_valid, 1'b0);
        check("mid_rst_rs_ready", rs_ready, 1'b1);
        check("mid_rst_result_valid", result_valid, 2'b00);
        idle();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_upd_valid", upd_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
